// File: rtl/pkt_rate_monitor_if.sv
// rtl/pkt_rate_monitor_if.sv - AXI-Stream handshake/keep bundle observed by the rate monitor
interface pkt_rate_monitor_if #(
    parameter int NUM_CH = 4,
    parameter int KEEP_W = 32
);
    logic [NUM_CH-1:0]        s_axis_tvalid;
    logic [NUM_CH-1:0]        s_axis_tready;
    logic [NUM_CH-1:0]        s_axis_tlast;
    logic [NUM_CH*KEEP_W-1:0] s_axis_tkeep;

    modport master (
        output s_axis_tvalid,
        output s_axis_tready,
        output s_axis_tlast,
        output s_axis_tkeep
    );

    modport slave (
        input s_axis_tvalid,
        input s_axis_tready,
        input s_axis_tlast,
        input s_axis_tkeep
    );
endinterface

// File: rtl/pkt_rate_monitor.sv
// rtl/pkt_rate_monitor.sv - per-channel packet/byte rate monitor over fixed windows
module pkt_rate_monitor #(
    parameter int NUM_CH              = 4,
    parameter int C_S_AXIS_DATA_WIDTH = 256,
    parameter int REG_DEPTH           = 32,
    parameter int INTERVAL_CYCLES     = 200000000
) (
    input  logic                        clk_200,
    input  logic                        resetn,
    input  logic                        clear,
    pkt_rate_monitor_if.slave           s_axis,
    output logic [NUM_CH*REG_DEPTH-1:0] pkt_rate,
    output logic [NUM_CH*REG_DEPTH-1:0] byte_rate,
    output logic                        rate_valid,
    output logic [REG_DEPTH-1:0]        window_count,
    output logic [NUM_CH-1:0]           sat_flag
);
    localparam int KEEP_W = C_S_AXIS_DATA_WIDTH / 8;
    localparam int TW     = $clog2(INTERVAL_CYCLES);
    localparam int PW     = $clog2(KEEP_W + 1);
    localparam logic [REG_DEPTH-1:0] CNT_MAX = '1;
    localparam logic [TW-1:0]        T_LAST  = TW'(INTERVAL_CYCLES - 1);

    logic [TW-1:0]        timer_q, timer_d;
    logic [REG_DEPTH-1:0] pkt_cnt_q  [NUM_CH];
    logic [REG_DEPTH-1:0] pkt_cnt_d  [NUM_CH];
    logic [REG_DEPTH-1:0] byte_cnt_q [NUM_CH];
    logic [REG_DEPTH-1:0] byte_cnt_d [NUM_CH];
    logic [REG_DEPTH-1:0] pkt_snap_q [NUM_CH];
    logic [REG_DEPTH-1:0] pkt_snap_d [NUM_CH];
    logic [REG_DEPTH-1:0] byte_snap_q[NUM_CH];
    logic [REG_DEPTH-1:0] byte_snap_d[NUM_CH];
    logic                 rate_valid_q, rate_valid_d;
    logic [REG_DEPTH-1:0] window_count_q, window_count_d;
    logic [NUM_CH-1:0]    sat_q, sat_d;

    logic                 boundary;
    logic [NUM_CH-1:0]    beat;
    logic [PW-1:0]        byte_inc[NUM_CH];
    logic [REG_DEPTH-1:0] pkt_sum [NUM_CH];
    logic [REG_DEPTH-1:0] byte_sum[NUM_CH];

    function automatic logic [PW-1:0] popcount(input logic [KEEP_W-1:0] k);
        logic [PW-1:0] n;
        n = '0;
        for (int b = 0; b < KEEP_W; b++) begin
            n = n + PW'(k[b]);
        end
        return n;
    endfunction

    // Carry out of the REG_DEPTH-bit adder clamps the result at all-ones.
    function automatic logic [REG_DEPTH-1:0] sat_add(input logic [REG_DEPTH-1:0] a,
                                                     input logic [REG_DEPTH-1:0] inc);
        logic [REG_DEPTH:0] s;
        s = {1'b0, a} + {1'b0, inc};
        return s[REG_DEPTH] ? CNT_MAX : s[REG_DEPTH-1:0];
    endfunction

    assign boundary = (timer_q == T_LAST);

    // Per-channel beat qualification and this cycle's saturated running sums.
    always_comb begin
        for (int ch = 0; ch < NUM_CH; ch++) begin
            beat[ch]     = s_axis.s_axis_tvalid[ch] & s_axis.s_axis_tready[ch];
            byte_inc[ch] = beat[ch] ? popcount(s_axis.s_axis_tkeep[ch*KEEP_W +: KEEP_W]) : '0;
            pkt_sum[ch]  = sat_add(pkt_cnt_q[ch],
                                   REG_DEPTH'(beat[ch] & s_axis.s_axis_tlast[ch]));
            byte_sum[ch] = sat_add(byte_cnt_q[ch], REG_DEPTH'(byte_inc[ch]));
        end
    end

    // Next-state: window timer, live counters, boundary snapshot; clear overrides the boundary.
    always_comb begin
        timer_d        = timer_q;
        rate_valid_d   = 1'b0;
        window_count_d = window_count_q;
        sat_d          = sat_q;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            pkt_cnt_d[ch]   = pkt_cnt_q[ch];
            byte_cnt_d[ch]  = byte_cnt_q[ch];
            pkt_snap_d[ch]  = pkt_snap_q[ch];
            byte_snap_d[ch] = byte_snap_q[ch];
        end

        if (clear) begin
            timer_d        = '0;
            window_count_d = '0;
            sat_d          = '0;
            for (int ch = 0; ch < NUM_CH; ch++) begin
                pkt_cnt_d[ch]  = '0;
                byte_cnt_d[ch] = '0;
            end
        end else begin
            timer_d = boundary ? '0 : timer_q + TW'(1);
            for (int ch = 0; ch < NUM_CH; ch++) begin
                if ((pkt_sum[ch] == CNT_MAX) || (byte_sum[ch] == CNT_MAX)) begin
                    sat_d[ch] = 1'b1;
                end
                if (boundary) begin
                    // The boundary cycle's own beat belongs to the closing window.
                    pkt_snap_d[ch]  = pkt_sum[ch];
                    byte_snap_d[ch] = byte_sum[ch];
                    pkt_cnt_d[ch]   = '0;
                    byte_cnt_d[ch]  = '0;
                end else begin
                    pkt_cnt_d[ch]  = pkt_sum[ch];
                    byte_cnt_d[ch] = byte_sum[ch];
                end
            end
            if (boundary) begin
                rate_valid_d   = 1'b1;
                window_count_d = window_count_q + REG_DEPTH'(1);
            end
        end
    end

    // State registers; reset discards any partial window and all published rates.
    always_ff @(posedge clk_200 or negedge resetn) begin
        if (!resetn) begin
            timer_q        <= '0;
            rate_valid_q   <= 1'b0;
            window_count_q <= '0;
            sat_q          <= '0;
            for (int ch = 0; ch < NUM_CH; ch++) begin
                pkt_cnt_q[ch]   <= '0;
                byte_cnt_q[ch]  <= '0;
                pkt_snap_q[ch]  <= '0;
                byte_snap_q[ch] <= '0;
            end
        end else begin
            timer_q        <= timer_d;
            rate_valid_q   <= rate_valid_d;
            window_count_q <= window_count_d;
            sat_q          <= sat_d;
            for (int ch = 0; ch < NUM_CH; ch++) begin
                pkt_cnt_q[ch]   <= pkt_cnt_d[ch];
                byte_cnt_q[ch]  <= byte_cnt_d[ch];
                pkt_snap_q[ch]  <= pkt_snap_d[ch];
                byte_snap_q[ch] <= byte_snap_d[ch];
            end
        end
    end

    // Pack snapshot registers onto the flat output buses.
    always_comb begin
        pkt_rate  = '0;
        byte_rate = '0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            pkt_rate[ch*REG_DEPTH +: REG_DEPTH]  = pkt_snap_q[ch];
            byte_rate[ch*REG_DEPTH +: REG_DEPTH] = byte_snap_q[ch];
        end
    end

    assign rate_valid   = rate_valid_q;
    assign window_count = window_count_q;
    assign sat_flag     = sat_q;
endmodule
